// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and fetch FSM states.
// Imported by the fetch stage and the decoder.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_BR = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instruction);
    return instruction[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of a raw instruction word into control-flow flags and target.
// Shared between the fetch stage and the decoder.
module fetch_predecode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic [INST_W-1:0] instruction,
  output logic              is_jmp,
  output logic              is_br,
  output logic [ADDR_W-1:0] target
);

  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode = opcode_of(instruction[15:0]);
  assign is_jmp = (opcode == OP_JMP);
  assign is_br  = (opcode == OP_BR);
  assign target = instruction[TGT_LSB +: ADDR_W];

  // Low operand bits only matter to the decoder.
  assign unused_operand = ^instruction[TGT_LSB-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, folds JMPs, stalls on BR until resolved,
// and presents fetched words through a one-entry valid/ready output register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter int          INST_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_instruction,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              br_resolve,
  input  logic              br_taken,
  output logic              stalled
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] br_target, br_target_n;
  logic [INST_W-1:0] inst_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic              inst_valid_n;

  logic              is_jmp;
  logic              is_br;
  logic [ADDR_W-1:0] target;
  logic              consumed;
  logic              slot_free;

  fetch_predecode #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_predecode (
    .instruction (rom_instruction),
    .is_jmp      (is_jmp),
    .is_br       (is_br),
    .target      (target)
  );

  assign rom_address = pc;
  assign stalled     = (state == WAIT_BR);
  assign consumed    = inst_valid && inst_ready;
  assign slot_free   = !inst_valid || inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= ADDR_W'(RESET_PC);
      br_target  <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      br_target  <= br_target_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      inst_valid <= inst_valid_n;
    end
  end

  // A consumed slot empties unless a new fetch refills it in the same cycle.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    br_target_n  = br_target;
    inst_n       = inst;
    inst_pc_n    = inst_pc;
    inst_valid_n = inst_valid && !consumed;

    case (state)
      RUN: begin
        if (en && slot_free) begin
          if (is_jmp) begin
            pc_n = target;
          end else begin
            inst_n       = rom_instruction;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = pc + ADDR_W'(1);
            if (is_br) begin
              br_target_n = target;
              state_n     = WAIT_BR;
            end
          end
        end
      end
      WAIT_BR: begin
        if (br_resolve) begin
          state_n = RUN;
          if (br_taken) begin
            pc_n = br_target;
          end
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a program-order model of the fetch stream.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  rom_address;
  logic [15:0] rom_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [3:0]  inst_pc;
  logic        br_resolve;
  logic        br_taken;
  logic        stalled;

  logic [15:0] rom [16];
  int tests_run    = 0;
  int tests_failed = 0;

  fetch_unit #(
    .ADDR_W   (4),
    .INST_W   (16),
    .RESET_PC (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .br_resolve      (br_resolve),
    .br_taken        (br_taken),
    .stalled         (stalled)
  );

  assign rom_instruction = rom[rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resolving a branch whose BR is still sitting unconsumed is a protocol violation.
  always @(posedge clk) begin
    if (rst_n && br_resolve)
      assert (!(inst_valid && inst[15:12] == OP_BR))
        else $error("[TB] protocol violation: br_resolve while BR unconsumed");
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_filler;
    for (int i = 0; i < 16; i++) rom[i] = {OP_LOAD, 4'(i), 4'(15 - i), 4'(i)};
  endtask

  task automatic do_reset;
    en         = 1'b0;
    inst_ready = 1'b0;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_pc(input logic [3:0] target);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (inst_valid && inst_pc == target) begin
        ok = 1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL reach_pc: got inst_pc=%0d valid=%b required inst_pc=%0d valid=1", inst_pc, inst_valid, target);
    end
  endtask

  task automatic test_reset;
    fill_filler();
    do_reset();
    tests_run++;
    if ({inst_valid, stalled, rom_address, inst_pc, inst} !== 26'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b stalled=%b addr=%0d inst_pc=%0d inst=%h required all zero",
               inst_valid, stalled, rom_address, inst_pc, inst);
    end
    tick();
    tests_run++;
    if (inst_valid !== 1'b0 || rom_address !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_en_low: got valid=%b addr=%0d required valid=0 addr=0", inst_valid, rom_address);
    end
  endtask

  task automatic test_sequence;
    fill_filler();
    rom[0] = 16'h1201;
    rom[1] = 16'hB401;
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    tests_run++;
    if (rom_address !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL seq_addr0: got %0d required 0", rom_address);
    end
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 16'h1201 || inst_pc !== 4'd0 || rom_address !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL seq_first: got v=%b inst=%h pc=%0d addr=%0d required v=1 inst=1201 pc=0 addr=1",
               inst_valid, inst, inst_pc, rom_address);
    end
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 16'hB401 || inst_pc !== 4'd1 || rom_address !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL seq_second: got v=%b inst=%h pc=%0d addr=%0d required v=1 inst=b401 pc=1 addr=2",
               inst_valid, inst, inst_pc, rom_address);
    end
  endtask

  task automatic test_jmp;
    fill_filler();
    rom[6] = 16'h8300;
    rom[3] = 16'hBE01;
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    run_to_pc(4'd5);
    tick();
    tests_run++;
    if (inst_valid !== 1'b0 || rom_address !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL jmp_bubble: got v=%b addr=%0d required v=0 addr=3", inst_valid, rom_address);
    end
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 16'hBE01 || inst_pc !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL jmp_target: got v=%b inst=%h pc=%0d required v=1 inst=be01 pc=3", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_branch(input bit taken);
    logic [3:0]  exp_pc;
    logic [15:0] exp_inst;
    fill_filler();
    rom[4]  = 16'hCA00;
    rom[10] = 16'hF200;
    exp_pc   = taken ? 4'd10 : 4'd5;
    exp_inst = taken ? 16'hF200 : rom[5];
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    run_to_pc(4'd4);
    tests_run++;
    if (inst !== 16'hCA00 || stalled !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL br_present: got inst=%h stalled=%b required inst=ca00 stalled=1", inst, stalled);
    end
    repeat (2) begin
      tick();
      tests_run++;
      if (inst_valid !== 1'b0 || stalled !== 1'b1 || rom_address !== 4'd5) begin
        tests_failed++;
        $display("[TB] FAIL br_wait: got v=%b stalled=%b addr=%0d required v=0 stalled=1 addr=5",
                 inst_valid, stalled, rom_address);
      end
    end
    br_resolve = 1'b1;
    br_taken   = taken;
    tick();
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || stalled !== 1'b0 || rom_address !== exp_pc) begin
      tests_failed++;
      $display("[TB] FAIL br_resolve taken=%0d: got v=%b stalled=%b addr=%0d required v=0 stalled=0 addr=%0d",
               taken, inst_valid, stalled, rom_address, exp_pc);
    end
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst) begin
      tests_failed++;
      $display("[TB] FAIL br_next taken=%0d: got v=%b pc=%0d inst=%h required v=1 pc=%0d inst=%h",
               taken, inst_valid, inst_pc, inst, exp_pc, exp_inst);
    end
  endtask

  task automatic test_backpressure;
    fill_filler();
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    run_to_pc(4'd2);
    inst_ready = 1'b0;
    repeat (3) begin
      tick();
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== 4'd2 || inst !== rom[2] || rom_address !== 4'd3) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold: got v=%b pc=%0d inst=%h addr=%0d required v=1 pc=2 inst=%h addr=3",
                 inst_valid, inst_pc, inst, rom_address, rom[2]);
      end
    end
    inst_ready = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      tick();
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== 4'(k) || inst !== rom[k]) begin
        tests_failed++;
        $display("[TB] FAIL bp_resume: got v=%b pc=%0d inst=%h required v=1 pc=%0d inst=%h",
                 inst_valid, inst_pc, inst, k, rom[k]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'd15;
    exp_seq[1] = 4'd0;
    exp_seq[2] = 4'd1;
    fill_filler();
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    run_to_pc(4'd14);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_seq[k] || inst !== rom[exp_seq[k]]) begin
        tests_failed++;
        $display("[TB] FAIL wrap: got v=%b pc=%0d inst=%h required v=1 pc=%0d inst=%h",
                 inst_valid, inst_pc, inst, exp_seq[k], rom[exp_seq[k]]);
      end
    end
  endtask

  task automatic test_async_reset;
    fill_filler();
    rom[4] = 16'hCA00;
    do_reset();
    en = 1'b1;
    inst_ready = 1'b1;
    run_to_pc(4'd4);
    inst_ready = 1'b0;
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || stalled !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL areset_pre: got v=%b stalled=%b required v=1 stalled=1", inst_valid, stalled);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (inst_valid !== 1'b0 || stalled !== 1'b0 || rom_address !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL areset_now: got v=%b stalled=%b addr=%0d required v=0 stalled=0 addr=0",
               inst_valid, stalled, rom_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    tests_run++;
    if (inst_valid !== 1'b1 || inst_pc !== 4'd0 || inst !== rom[0]) begin
      tests_failed++;
      $display("[TB] FAIL areset_refetch: got v=%b pc=%0d inst=%h required v=1 pc=0 inst=%h",
               inst_valid, inst_pc, inst, rom[0]);
    end
  endtask

  task automatic test_random;
    logic [3:0]  plain_ops [6];
    logic [3:0]  exp_pc, p, br_pc, br_tgt, hold_pc;
    logic [15:0] hold_inst;
    bit          hold, no_fetch, awaiting, just_resolved;
    int          handshakes;
    plain_ops[0] = OP_LOAD; plain_ops[1] = OP_ADD; plain_ops[2] = OP_SUB;
    plain_ops[3] = OP_SUBI; plain_ops[4] = OP_MOV; plain_ops[5] = OP_OUT;
    // JMPs only jump forward so every JMP chain ends on a real instruction.
    for (int a = 0; a < 16; a++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2 && a < 15)
        rom[a] = {OP_JMP, 4'($urandom_range(a + 1, 15)), 8'($urandom)};
      else if (r < 4)
        rom[a] = {OP_BR, 4'($urandom), 8'($urandom)};
      else
        rom[a] = {plain_ops[$urandom_range(0, 5)], 12'($urandom)};
    end
    do_reset();
    exp_pc = 4'd0; br_pc = 4'd0; br_tgt = 4'd0; hold_pc = 4'd0; hold_inst = 16'd0;
    hold = 0; no_fetch = 0; awaiting = 0; just_resolved = 0;
    handshakes = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold) begin
        tests_run++;
        if (inst_valid !== 1'b1 || inst !== hold_inst || inst_pc !== hold_pc) begin
          tests_failed++;
          $display("[TB] FAIL rnd_hold cyc=%0d: got v=%b inst=%h pc=%0d required v=1 inst=%h pc=%0d",
                   cyc, inst_valid, inst, inst_pc, hold_inst, hold_pc);
        end
      end
      if (no_fetch) begin
        tests_run++;
        if (inst_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rnd_en_low cyc=%0d: got v=%b required v=0", cyc, inst_valid);
        end
      end
      if (awaiting) begin
        tests_run++;
        if (stalled !== 1'b1 || inst_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rnd_stall cyc=%0d: got stalled=%b v=%b required stalled=1 v=0", cyc, stalled, inst_valid);
        end
      end
      if (just_resolved) begin
        tests_run++;
        if (stalled !== 1'b0 || inst_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rnd_resolve cyc=%0d: got stalled=%b v=%b required stalled=0 v=0", cyc, stalled, inst_valid);
        end
      end
      if (inst_valid && inst[15:12] == OP_BR) begin
        tests_run++;
        if (stalled !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rnd_br_stalled cyc=%0d: got stalled=%b required 1", cyc, stalled);
        end
      end

      just_resolved = 0;
      br_resolve    = 1'b0;
      br_taken      = 1'b0;
      if (awaiting && $urandom_range(0, 2) == 0) begin
        br_resolve    = 1'b1;
        br_taken      = 1'($urandom_range(0, 1));
        exp_pc        = br_taken ? br_tgt : 4'(br_pc + 4'd1);
        awaiting      = 0;
        just_resolved = 1;
      end
      en         = ($urandom_range(0, 4) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      hold       = inst_valid && !inst_ready;
      hold_inst  = inst;
      hold_pc    = inst_pc;
      no_fetch   = !en && (!inst_valid || inst_ready);

      if (inst_valid && inst_ready) begin
        p = exp_pc;
        for (int k = 0; k < 16 && rom[p][15:12] == OP_JMP; k++) p = rom[p][11:8];
        tests_run++;
        if (inst_pc !== p || inst !== rom[p]) begin
          tests_failed++;
          $display("[TB] FAIL rnd_stream cyc=%0d: got pc=%0d inst=%h required pc=%0d inst=%h",
                   cyc, inst_pc, inst, p, rom[p]);
        end
        handshakes++;
        if (rom[p][15:12] == OP_BR) begin
          awaiting = 1;
          br_pc    = p;
          br_tgt   = rom[p][11:8];
        end else begin
          exp_pc = 4'(p + 4'd1);
        end
      end
      tick();
    end
    en         = 1'b0;
    br_resolve = 1'b0;
    tests_run++;
    if (handshakes < 200) begin
      tests_failed++;
      $display("[TB] FAIL rnd_progress: got %0d handshakes required at least 200", handshakes);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    inst_ready = 1'b0;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    fill_filler();
    @(negedge clk);
    test_reset();
    test_sequence();
    test_jmp();
    test_branch(1'b1);
    test_branch(1'b0);
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
